// File: rtl/vga_timing_if.sv
// VGA raster timing bundle.
// master: the timing generator (takes enable, drives timing/coordinate outputs).
// slave : the consumer (frame-buffer readout, RGB output stage) that owns enable.
//   enable      run (1) / stop-and-clear (0)
//   pix_en      one-clk strobe per pixel period
//   h_sync      horizontal sync, polarity set by the generator
//   v_sync      vertical sync, polarity set by the generator
//   de          display enable, high inside the active area
//   x_pixel     column of the current output pixel
//   y_pixel     row of the current output pixel
//   y_fetch     row plus fetch lookahead, wrapped to the frame height
//   line_start  one-clk pulse when x_pixel becomes 0
//   frame_start one-clk pulse when (x_pixel, y_pixel) becomes (0,0)
interface vga_timing_if #(
  parameter int CW = 10
);
  logic          enable;
  logic          pix_en;
  logic          h_sync;
  logic          v_sync;
  logic          de;
  logic [CW-1:0] x_pixel;
  logic [CW-1:0] y_pixel;
  logic [CW-1:0] y_fetch;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  enable,
    output pix_en, h_sync, v_sync, de, x_pixel, y_pixel, y_fetch,
           line_start, frame_start
  );

  modport slave (
    output enable,
    input  pix_en, h_sync, v_sync, de, x_pixel, y_pixel, y_fetch,
           line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator running entirely in the clk domain.
// A clock divider produces a one-clk pix_en strobe every CLK_DIV clks; the
// horizontal/vertical counters advance on that strobe and a registered output
// stage presents sync, display enable, coordinates, a lookahead fetch row and
// line/frame start pulses one pixel period after the counter value.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high; same cleared state as enable=0
//   vga    vga_timing_if master modport (enable in, timing outputs out)
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int Y_LOOKAHEAD = 2,
  parameter int CW          = 10
) (
  input logic          clk,
  input logic          reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] LOOK     = CW'(Y_LOOKAHEAD);
  localparam logic [CW:0]   LOOK_W   = (CW+1)'(Y_LOOKAHEAD);
  localparam logic [CW:0]   V_TOT_W  = (CW+1)'(V_TOTAL);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  // Half-open window test used for both sync pulses.
  function automatic logic in_window(input logic [CW-1:0] cnt,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  // Row plus lookahead, wrapped once; the extra bit keeps the sum exact.
  function automatic logic [CW-1:0] fetch_row(input logic [CW-1:0] row);
    logic [CW:0] sum;
    sum = {1'b0, row} + LOOK_W;
    if (sum >= V_TOT_W) sum = sum - V_TOT_W;
    return sum[CW-1:0];
  endfunction

  logic [DW-1:0] div_cnt_p0;
  logic          pix_en_p0;
  logic [CW-1:0] h_cnt_p0;
  logic [CW-1:0] v_cnt_p0;

  logic          h_sync_p1;
  logic          v_sync_p1;
  logic          de_p1;
  logic [CW-1:0] x_pixel_p1;
  logic [CW-1:0] y_pixel_p1;
  logic [CW-1:0] y_fetch_p1;
  logic          line_start_p1;
  logic          frame_start_p1;

  logic div_last;
  logic h_last;
  logic v_last;

  assign div_last = (div_cnt_p0 == DIV_LAST);
  assign h_last   = (h_cnt_p0 == H_LAST);
  assign v_last   = (v_cnt_p0 == V_LAST);

  // Stage p0: clock divider, pixel strobe and raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_p0 <= '0;
      pix_en_p0  <= 1'b0;
      h_cnt_p0   <= '0;
      v_cnt_p0   <= '0;
    end else if (!vga.enable) begin
      div_cnt_p0 <= '0;
      pix_en_p0  <= 1'b0;
      h_cnt_p0   <= '0;
      v_cnt_p0   <= '0;
    end else begin
      div_cnt_p0 <= div_last ? '0 : div_cnt_p0 + 1'b1;
      pix_en_p0  <= div_last;
      if (pix_en_p0) begin
        h_cnt_p0 <= h_last ? '0 : h_cnt_p0 + 1'b1;
        if (h_last) v_cnt_p0 <= v_last ? '0 : v_cnt_p0 + 1'b1;
      end
    end
  end

  // Stage p1: registered outputs, loaded from the counters on pix_en only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync_p1      <= ~HS_ON;
      v_sync_p1      <= ~VS_ON;
      de_p1          <= 1'b0;
      x_pixel_p1     <= '0;
      y_pixel_p1     <= '0;
      y_fetch_p1     <= LOOK;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else if (!vga.enable) begin
      h_sync_p1      <= ~HS_ON;
      v_sync_p1      <= ~VS_ON;
      de_p1          <= 1'b0;
      x_pixel_p1     <= '0;
      y_pixel_p1     <= '0;
      y_fetch_p1     <= LOOK;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      // Strobes default low so they last one clk even when CLK_DIV > 1.
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      if (pix_en_p0) begin
        h_sync_p1      <= in_window(h_cnt_p0, H_SS, H_SE) ? HS_ON : ~HS_ON;
        v_sync_p1      <= in_window(v_cnt_p0, V_SS, V_SE) ? VS_ON : ~VS_ON;
        de_p1          <= (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
        x_pixel_p1     <= h_cnt_p0;
        y_pixel_p1     <= v_cnt_p0;
        y_fetch_p1     <= fetch_row(v_cnt_p0);
        line_start_p1  <= (h_cnt_p0 == '0);
        frame_start_p1 <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      end
    end
  end

  assign vga.pix_en      = pix_en_p0;
  assign vga.h_sync      = h_sync_p1;
  assign vga.v_sync      = v_sync_p1;
  assign vga.de          = de_p1;
  assign vga.x_pixel     = x_pixel_p1;
  assign vga.y_pixel     = y_pixel_p1;
  assign vga.y_fetch     = y_fetch_p1;
  assign vga.line_start  = line_start_p1;
  assign vga.frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen.
// dut_a: CLK_DIV=4, default horizontal timing, short 4/1/1/1 vertical timing
//        (V_TOTAL=7), active-low syncs, Y_LOOKAHEAD=2.
// dut_b: CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, active-high syncs, Y_LOOKAHEAD=3.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(10)) va ();
  vga_timing_if #(.CW(10)) vb ();

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .Y_LOOKAHEAD(2), .CW(10)
  ) dut_a (
    .clk(clk), .reset(reset), .vga(va)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .Y_LOOKAHEAD(3), .CW(10)
  ) dut_b (
    .clk(clk), .reset(reset), .vga(vb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Aggregates collected by scan_a.
  int s_a, gap_bad, hold_err, rast_err, hs_err, hs_low0, hs_first_x;
  int vs_err, vs_low, de_cnt, de_err, fetch_err, fetch_at5, fetch_at6;
  int ls_cnt, ls_err, fs_cnt, fs_err, strobe_err, b_idle_err;
  int end_ls, end_fs, end_x, end_y;
  logic [9:0] x_hold;

  int lat, found;
  int b_pix_low, b_rast, b_hs_err, b_hs_hi, b_vs_err, b_de_cnt, b_de_err;
  int b_fetch, b_fs_cnt, b_ls_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until the selected instance shows pix_en high (bounded).
  task automatic count_to_pix(input bit sel_b, output int n);
    n = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n++;
      if ((sel_b ? vb.pix_en : va.pix_en) === 1'b1) break;
    end
  endtask

  // Walks dut_a for n output updates, starting at a negedge where an update
  // has just been presented. Expected coordinates follow raster order; the
  // rule-based aggregates cover every update except the last, whose values
  // are recorded in end_*.
  task automatic scan_a(input int n);
    int ex, ey, gap;
    logic prev_pix;
    s_a = 0; gap_bad = 0; hold_err = 0; rast_err = 0; hs_err = 0;
    hs_low0 = 0; hs_first_x = -1; vs_err = 0; vs_low = 0; de_cnt = 0;
    de_err = 0; fetch_err = 0; fetch_at5 = -1; fetch_at6 = -1; ls_cnt = 0;
    ls_err = 0; fs_cnt = 0; fs_err = 0; strobe_err = 0; b_idle_err = 0;
    end_ls = -1; end_fs = -1; end_x = -1; end_y = -1;
    ex = 0; ey = 0; gap = 0; prev_pix = 1'b1; x_hold = va.x_pixel;
    for (int c = 0; c < n * 4 + 64 && s_a < n; c++) begin
      if (c > 0) @(negedge clk);
      gap++;
      if (vb.pix_en !== 1'b0) b_idle_err++;
      if (prev_pix) begin
        if (s_a > 0 && gap != 4) gap_bad++;
        gap = 0;
        if (va.x_pixel !== ex[9:0] || va.y_pixel !== ey[9:0]) rast_err++;
        if (s_a < n - 1) begin
          if ((va.h_sync === 1'b0) != (ex >= 656 && ex < 752)) hs_err++;
          if (va.h_sync === 1'b0 && ey == 0) hs_low0++;
          if (va.h_sync === 1'b0 && hs_first_x < 0) hs_first_x = ex;
          if ((va.v_sync === 1'b0) != (ey == 5)) vs_err++;
          if (va.v_sync === 1'b0) vs_low++;
          if (va.de === 1'b1) de_cnt++;
          if ((va.de === 1'b1) != (ex < 640 && ey < 4)) de_err++;
          if (va.y_fetch !== 10'((ey + 2) % 7)) fetch_err++;
          if (ey == 5 && ex == 0) fetch_at5 = int'(va.y_fetch);
          if (ey == 6 && ex == 0) fetch_at6 = int'(va.y_fetch);
          if (va.line_start === 1'b1) ls_cnt++;
          if ((va.line_start === 1'b1) != (ex == 0)) ls_err++;
          if (va.frame_start === 1'b1) fs_cnt++;
          if ((va.frame_start === 1'b1) != (ex == 0 && ey == 0)) fs_err++;
        end else begin
          end_ls = int'(va.line_start);
          end_fs = int'(va.frame_start);
          end_x  = int'(va.x_pixel);
          end_y  = int'(va.y_pixel);
        end
        ex++;
        if (ex == 800) begin
          ex = 0;
          ey = (ey == 6) ? 0 : ey + 1;
        end
        s_a++;
      end else begin
        if (va.line_start !== 1'b0 || va.frame_start !== 1'b0) strobe_err++;
        if (va.x_pixel !== x_hold) hold_err++;
      end
      x_hold   = va.x_pixel;
      prev_pix = va.pix_en;
    end
  endtask

  initial begin
    reset = 1'b1;
    va.enable = 1'b0;
    vb.enable = 1'b0;

    // Reset state of both instances
    #1;
    chk("a_rst_pix_en", va.pix_en, 0);
    chk("a_rst_h_sync", va.h_sync, 1);
    chk("a_rst_v_sync", va.v_sync, 1);
    chk("a_rst_de", va.de, 0);
    chk("a_rst_x", va.x_pixel, 0);
    chk("a_rst_y", va.y_pixel, 0);
    chk("a_rst_y_fetch", va.y_fetch, 2);
    chk("a_rst_line_start", va.line_start, 0);
    chk("a_rst_frame_start", va.frame_start, 0);
    chk("b_rst_h_sync", vb.h_sync, 0);
    chk("b_rst_v_sync", vb.v_sync, 0);
    chk("b_rst_y_fetch", vb.y_fetch, 3);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // A: enable, first strobe and first output update
    @(negedge clk);
    va.enable = 1'b1;
    count_to_pix(1'b0, lat);
    chk("a_pix_en_latency", lat, 4);
    @(negedge clk);
    chk("a_first_frame_start", va.frame_start, 1);
    chk("a_first_line_start", va.line_start, 1);
    chk("a_first_x", va.x_pixel, 0);
    chk("a_first_y", va.y_pixel, 0);
    chk("a_first_de", va.de, 1);
    chk("a_first_h_sync", va.h_sync, 1);
    chk("a_first_y_fetch", va.y_fetch, 2);

    // A: one full frame plus the first update of the next
    scan_a(5601);
    chk("a_frame_updates", s_a, 5601);
    chk("a_pix_period_errs", gap_bad, 0);
    chk("a_hold_errs", hold_err, 0);
    chk("a_raster_errs", rast_err, 0);
    chk("a_hs_first_x", hs_first_x, 656);
    chk("a_hs_low_line0", hs_low0, 96);
    chk("a_hs_rule_errs", hs_err, 0);
    chk("a_vs_rule_errs", vs_err, 0);
    chk("a_vs_low_count", vs_low, 800);
    chk("a_de_count", de_cnt, 2560);
    chk("a_de_rule_errs", de_err, 0);
    chk("a_fetch_errs", fetch_err, 0);
    chk("a_fetch_y5", fetch_at5, 0);
    chk("a_fetch_y6", fetch_at6, 1);
    chk("a_line_start_count", ls_cnt, 7);
    chk("a_line_start_errs", ls_err, 0);
    chk("a_frame_start_count", fs_cnt, 1);
    chk("a_frame_start_errs", fs_err, 0);
    chk("a_strobe_width_errs", strobe_err, 0);
    chk("a_next_frame_start", end_fs, 1);
    chk("a_next_frame_x", end_x, 0);
    chk("a_next_frame_y", end_y, 0);
    chk("b_idle_while_disabled", b_idle_err, 0);

    // A: drop enable at (300,1), re-enable five clks later
    found = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (va.x_pixel === 10'd300 && va.y_pixel === 10'd1) begin
        found = 1;
        break;
      end
    end
    chk("a_reach_x300_y1", found, 1);
    chk("a_de_at_x300", va.de, 1);
    va.enable = 1'b0;
    @(negedge clk);
    chk("a_stop_x", va.x_pixel, 0);
    chk("a_stop_y", va.y_pixel, 0);
    chk("a_stop_de", va.de, 0);
    chk("a_stop_pix_en", va.pix_en, 0);
    chk("a_stop_h_sync", va.h_sync, 1);
    chk("a_stop_v_sync", va.v_sync, 1);
    chk("a_stop_y_fetch", va.y_fetch, 2);
    repeat (4) @(negedge clk);
    va.enable = 1'b1;
    count_to_pix(1'b0, lat);
    chk("a_restart_pix_latency", lat, 4);
    @(negedge clk);
    chk("a_restart_frame_start", va.frame_start, 1);
    chk("a_restart_x", va.x_pixel, 0);
    chk("a_restart_y", va.y_pixel, 0);

    // A: asynchronous reset between clock edges, mid-line
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (va.x_pixel === 10'd20 && va.y_pixel === 10'd0) begin
        found = 1;
        break;
      end
    end
    chk("a_reach_x20", found, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("a_async_rst_x", va.x_pixel, 0);
    chk("a_async_rst_de", va.de, 0);
    chk("a_async_rst_h_sync", va.h_sync, 1);
    chk("a_async_rst_y_fetch", va.y_fetch, 2);
    @(negedge clk);
    reset = 1'b0;
    count_to_pix(1'b0, lat);
    chk("a_post_rst_pix_latency", lat, 4);
    @(negedge clk);
    chk("a_post_rst_frame_start", va.frame_start, 1);
    scan_a(801);
    chk("a_post_rst_updates", s_a, 801);
    chk("a_post_rst_period_errs", gap_bad, 0);
    chk("a_post_rst_raster_errs", rast_err, 0);
    chk("a_post_rst_hs_first_x", hs_first_x, 656);
    chk("a_post_rst_hs_low", hs_low0, 96);
    chk("a_post_rst_hs_errs", hs_err, 0);
    chk("a_post_rst_de_count", de_cnt, 640);
    chk("a_post_rst_line1_ls", end_ls, 1);
    chk("a_post_rst_line1_fs", end_fs, 0);
    chk("a_post_rst_line1_x", end_x, 0);
    chk("a_post_rst_line1_y", end_y, 1);

    // B: CLK_DIV=1, active-high syncs, 14x7 raster
    @(negedge clk);
    vb.enable = 1'b1;
    count_to_pix(1'b1, lat);
    chk("b_pix_latency", lat, 1);
    @(negedge clk);
    chk("b_first_frame_start", vb.frame_start, 1);
    chk("b_first_x", vb.x_pixel, 0);
    b_pix_low = 0; b_rast = 0; b_hs_err = 0; b_hs_hi = 0; b_vs_err = 0;
    b_de_cnt = 0; b_de_err = 0; b_fetch = 0; b_fs_cnt = 0; b_ls_cnt = 0;
    for (int s = 0; s < 197; s++) begin
      int bx, by;
      if (s > 0) @(negedge clk);
      bx = s % 14;
      by = (s / 14) % 7;
      if (vb.pix_en !== 1'b1) b_pix_low++;
      if (vb.x_pixel !== bx[9:0] || vb.y_pixel !== by[9:0]) b_rast++;
      if ((vb.h_sync === 1'b1) != (bx == 10 || bx == 11)) b_hs_err++;
      if (s < 98 && vb.h_sync === 1'b1) b_hs_hi++;
      if ((vb.v_sync === 1'b1) != (by == 5)) b_vs_err++;
      if (s < 98 && vb.de === 1'b1) b_de_cnt++;
      if ((vb.de === 1'b1) != (bx < 8 && by < 4)) b_de_err++;
      if (vb.y_fetch !== 10'((by + 3) % 7)) b_fetch++;
      if (vb.frame_start === 1'b1) b_fs_cnt++;
      if (vb.line_start === 1'b1) b_ls_cnt++;
    end
    chk("b_pix_en_low", b_pix_low, 0);
    chk("b_raster_errs", b_rast, 0);
    chk("b_hs_rule_errs", b_hs_err, 0);
    chk("b_hs_high_count", b_hs_hi, 14);
    chk("b_vs_rule_errs", b_vs_err, 0);
    chk("b_de_count", b_de_cnt, 32);
    chk("b_de_rule_errs", b_de_err, 0);
    chk("b_fetch_errs", b_fetch, 0);
    chk("b_frame_start_count", b_fs_cnt, 3);
    chk("b_line_start_count", b_ls_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 decoder.
- Runs on the system clock. It emits a one-cycle pixel-enable strobe instead of a derived clock, so downstream logic stays in the single clk domain.
- Adds programmable timing and sync polarity, a run/stop control, a configurable line-fetch lookahead, and frame/line start strobes.
- Feeds the camera/filter frame buffer readout and the RGB output stage.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (>=1; 1 means pix_en is held high)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of h_sync (0 = active-low)
- VS_POL, 0, asserted level of v_sync
- Y_LOOKAHEAD, 2, lines of lead on y_fetch (0..V_TOTAL-1)
- CW, 10, width of the coordinate counters; must hold H_TOTAL-1 and V_TOTAL-1

Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- enable  in  1  run when 1; synchronous stop-and-clear when 0
- pix_en  out  1  one-clk strobe marking each pixel period
- h_sync  out  1  horizontal sync, polarity per HS_POL
- v_sync  out  1  vertical sync, polarity per VS_POL
- de  out  1  display enable (active area)
- x_pixel  out  CW  column of the current output pixel
- y_pixel  out  CW  row of the current output pixel
- y_fetch  out  CW  row plus Y_LOOKAHEAD, wrapped modulo V_TOTAL
- line_start  out  1  one-clk pulse when output x_pixel becomes 0
- frame_start  out  1  one-clk pulse when output (x_pixel, y_pixel) becomes (0,0)

Behaviour:
- Reset (async) and enable=0 (sync) give the same state:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0, pix_en = 0
  - h_sync = ~HS_POL, v_sync = ~VS_POL
  - de = 0, x_pixel = 0, y_pixel = 0, y_fetch = Y_LOOKAHEAD
  - line_start = 0, frame_start = 0
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while enable=1.
  - pix_en is registered and goes high for exactly one clk when div_cnt == CLK_DIV-1.
  - First pix_en occurs CLK_DIV clks after enable rises.
  - CLK_DIV=1: pix_en is high on every clk while enabled.
- Counters advance only on clks where pix_en=1:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the same cycle h_cnt wraps, and wraps V_TOTAL-1 -> 0.
- Output stage:
  - Registered on pix_en cycles only; otherwise all outputs hold.
  - Latency is one pixel period from counter value to output.
  - h_sync is asserted (== HS_POL) iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - v_sync uses the same rule with the V_* parameters and VS_POL.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - x_pixel = h_cnt, y_pixel = v_cnt.
  - y_fetch = v_cnt + Y_LOOKAHEAD, minus V_TOTAL if the sum >= V_TOTAL. The sum is computed at CW+1 bits, so no overflow.
- Strobes:
  - line_start and frame_start are high only on the pix_en cycle that loads x_pixel=0 (and, for frame_start, also y_pixel=0).
  - Both clear on the next clk, so they are one clk wide regardless of CLK_DIV.
- enable dropped mid-frame: clear on the next clk. Re-enabling always restarts at (0,0), and the first output update produces frame_start.
- Reset mid-frame: immediate async clear, same values as above.
- No state machine beyond run/idle. Idle is entered on reset or enable=0; run is entered when enable=1.

Test Plan:
1. Defaults, enable=1 from reset -> pix_en period 4 clks; h_sync low for exactly 96 pix_en strobes per line, starting when x_pixel=656; line length 800 strobes.
2. Defaults, full frame -> v_sync low while y_pixel is 490..491; de high for exactly 640x480 = 307200 strobes; frame_start once every 420000 strobes.
3. y_fetch wrap, Y_LOOKAHEAD=2 -> y_fetch=0 when y_pixel=523, y_fetch=1 when y_pixel=524, y_fetch=2 when y_pixel=0.
4. CLK_DIV=1, HS_POL=1, VS_POL=1, small timing (H 8/2/2/2, V 4/1/1/1) -> pix_en constantly high; h_sync high at x=10..11; 14x7 total cycle repeats; de high for 32 of every 98 clks.
5. enable dropped at x=300, y=100, then raised 5 clks later -> outputs return to reset values one clk after the drop; first output update after re-enable has x=0, y=0 with frame_start=1.
6. Async reset asserted mid-line between clk edges -> outputs clear without waiting for a clk edge; after release, behaviour matches scenario 1 cycle-for-cycle.
